// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-network winner-take-all logic.
package snn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } wta_state_e;

   localparam int INH_LVL1_DEF = 458752;
   localparam int INH_LVL2_DEF = 655360;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << r) < value) r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/grp_argmax.sv
// Combinational argmax over one group's counters; the lowest index wins ties.
module grp_argmax
   import snn_pkg::*;
#(
   parameter  int NUM_NRN = 18,
   parameter  int CNT_W   = 7,
   localparam int IDX_W   = clog2(NUM_NRN)
) (
   input  logic [NUM_NRN*CNT_W-1:0] i_cnt,
   output logic [IDX_W-1:0]         o_idx,
   output logic [CNT_W-1:0]         o_max,
   output logic                     o_eq
);

   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] mx;
   logic             eq;

   always_comb begin
      idx = '0;
      mx  = i_cnt[CNT_W-1:0];
      for (int n = 1; n < NUM_NRN; n++) begin
         if (i_cnt[n*CNT_W +: CNT_W] > mx) begin
            mx  = i_cnt[n*CNT_W +: CNT_W];
            idx = IDX_W'(n);
         end
      end
      // A second neuron matching the maximum marks the group as tied.
      eq = 1'b0;
      for (int n = 0; n < NUM_NRN; n++) begin
         if ((n != int'(idx)) && (i_cnt[n*CNT_W +: CNT_W] == mx)) eq = 1'b1;
      end
   end

   assign o_idx = idx;
   assign o_max = mx;
   assign o_eq  = eq;

endmodule

// File: rtl/wta_arbiter.sv
// Winner-take-all arbiter: serial per-group argmax search plus a global
// inhibition level derived from the per-step spike counts of all groups.
module wta_arbiter
   import snn_pkg::*;
#(
   parameter  int NUM_GRP  = 8,
   parameter  int NUM_NRN  = 18,
   parameter  int CNT_W    = 7,
   parameter  int SPK_W    = 5,
   parameter  int INH_W    = 25,
   parameter  int INH_LVL1 = INH_LVL1_DEF,
   parameter  int INH_LVL2 = INH_LVL2_DEF,
   localparam int WIN_W    = clog2(NUM_GRP*NUM_NRN),
   localparam int GRP_W    = clog2(NUM_GRP)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            i_start,
   input  logic                            i_cnt_clr,
   input  logic [NUM_GRP*NUM_NRN*CNT_W-1:0] i_cnt,
   input  logic [NUM_GRP-1:0]              i_grp_valid,
   input  logic [NUM_GRP*SPK_W-1:0]        i_grp_spk,
   output logic signed [INH_W-1:0]         o_inh,
   output logic                            o_inh_upd,
   output logic                            o_busy,
   output logic                            o_done,
   output logic [WIN_W-1:0]                o_winner,
   output logic [CNT_W-1:0]                o_win_cnt,
   output logic                            o_win_valid,
   output logic                            o_tie
);

   localparam int IDX_W = clog2(NUM_NRN);
   localparam int SUM_W = SPK_W + GRP_W;

   wta_state_e                 state;
   logic [GRP_W-1:0]           grp_ptr;
   logic [NUM_NRN*CNT_W-1:0]   grp_cnt;
   logic [IDX_W-1:0]           grp_idx;
   logic [CNT_W-1:0]           grp_max;
   logic                       grp_eq;
   logic [WIN_W-1:0]           cand_idx;
   logic [WIN_W-1:0]           best_idx;
   logic [CNT_W-1:0]           best_cnt;
   logic                       best_tie;
   logic [SUM_W-1:0]           spk_sum;

   always_comb begin
      grp_cnt  = i_cnt[int'(grp_ptr)*NUM_NRN*CNT_W +: NUM_NRN*CNT_W];
      cand_idx = WIN_W'(int'(grp_ptr) * NUM_NRN + int'(grp_idx));
   end

   grp_argmax #(
      .NUM_NRN (NUM_NRN),
      .CNT_W   (CNT_W)
   ) u_grp_argmax (
      .i_cnt (grp_cnt),
      .o_idx (grp_idx),
      .o_max (grp_max),
      .o_eq  (grp_eq)
   );

   assign o_busy = (state != ST_IDLE);

   // Search FSM: one group per SCAN cycle, results published from DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         grp_ptr     <= '0;
         best_idx    <= '0;
         best_cnt    <= '0;
         best_tie    <= 1'b0;
         o_done      <= 1'b0;
         o_winner    <= '0;
         o_win_cnt   <= '0;
         o_win_valid <= 1'b0;
         o_tie       <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (i_cnt_clr) begin
            state       <= ST_IDLE;
            grp_ptr     <= '0;
            best_idx    <= '0;
            best_cnt    <= '0;
            best_tie    <= 1'b0;
            o_winner    <= '0;
            o_win_cnt   <= '0;
            o_win_valid <= 1'b0;
            o_tie       <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (i_start) begin
                     state   <= ST_SCAN;
                     grp_ptr <= '0;
                  end
               end
               ST_SCAN: begin
                  // Strictly-greater replacement keeps the lowest global index on ties.
                  if ((grp_ptr == '0) || (grp_max > best_cnt)) begin
                     best_idx <= cand_idx;
                     best_cnt <= grp_max;
                     best_tie <= grp_eq;
                  end else if (grp_max == best_cnt) begin
                     best_tie <= 1'b1;
                  end
                  if (grp_ptr == GRP_W'(NUM_GRP-1)) begin
                     state   <= ST_DONE;
                     grp_ptr <= '0;
                  end else begin
                     grp_ptr <= grp_ptr + 1'b1;
                  end
               end
               ST_DONE: begin
                  state       <= ST_IDLE;
                  o_done      <= 1'b1;
                  o_winner    <= best_idx;
                  o_win_cnt   <= best_cnt;
                  o_win_valid <= (best_cnt != '0);
                  // All-zero counters are not reported as a tie.
                  o_tie       <= best_tie && (best_cnt != '0);
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      spk_sum = '0;
      for (int g = 0; g < NUM_GRP; g++) begin
         spk_sum = spk_sum + SUM_W'(i_grp_spk[g*SPK_W +: SPK_W]);
      end
   end

   // Inhibition level, refreshed only when every group reports its step count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_inh     <= '0;
         o_inh_upd <= 1'b0;
      end else begin
         o_inh_upd <= &i_grp_valid;
         if (&i_grp_valid) begin
            if (spk_sum == '0) begin
               o_inh <= '0;
            end else if (spk_sum == SUM_W'(1)) begin
               o_inh <= INH_W'(INH_LVL1);
            end else begin
               o_inh <= INH_W'(INH_LVL2);
            end
         end
      end
   end

endmodule
